mem_port_arbiter: RTL and testbench

// - Shares one memory port between instruction fetch (I) and data access (D, driven by the control unit's READ/WRITE).
// - Each side sees a private READ/WRITE/BUSYWAIT port; the arbiter sequences one access at a time to memory (M).
// - Sits between the IF/MEM pipeline stages and the unified memory model; owns the stall (BUSYWAIT) seen by both.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D), one access at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: D has priority).
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_READ,
   input  logic [ADDR_W-1:0] I_ADDRESS,
   output logic [DATA_W-1:0] I_READDATA,
   output logic              I_BUSYWAIT,
   input  logic              D_READ,
   input  logic              D_WRITE,
   input  logic [ADDR_W-1:0] D_ADDRESS,
   input  logic [DATA_W-1:0] D_WRITEDATA,
   output logic [DATA_W-1:0] D_READDATA,
   output logic              D_BUSYWAIT,
   output logic              M_READ,
   output logic              M_WRITE,
   output logic [ADDR_W-1:0] M_ADDRESS,
   output logic [DATA_W-1:0] M_WRITEDATA,
   input  logic [DATA_W-1:0] M_READDATA,
   input  logic              M_BUSYWAIT,
   output logic              ERR
);

   // state  | meaning
   // IDLE   | no access in flight; arbitrate at the next edge
   // ACCESS | memory strobe held, waiting for M_BUSYWAIT low
   // DONE   | one cycle; granted side released, READDATA valid
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   localparam logic       GNT_I     = 1'b0;
   localparam logic       GNT_D     = 1'b1;
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic                m_read_q, m_read_d;
   logic                m_write_q, m_write_d;
   logic [ADDR_W-1:0]   m_address_q, m_address_d;
   logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
   logic [DATA_W-1:0]   i_readdata_q, i_readdata_d;
   logic [DATA_W-1:0]   d_readdata_q, d_readdata_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                req_i, req_d, gnt_sel;

`ifdef ARB_ROUND_ROBIN_EN
   logic                last_grant_q, last_grant_d;
`endif

   assign req_i = I_READ;
   assign req_d = D_READ | D_WRITE;

`ifdef ARB_ROUND_ROBIN_EN
   assign gnt_sel = (req_i & req_d) ? ~last_grant_q : req_d;
`else
   assign gnt_sel = req_d;
`endif

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      m_read_d      = m_read_q;
      m_write_d     = m_write_q;
      m_address_d   = m_address_q;
      m_writedata_d = m_writedata_q;
      i_readdata_d  = i_readdata_q;
      d_readdata_d  = d_readdata_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d  = last_grant_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_i | req_d) begin
               state_d = ST_ACCESS;
               grant_d = gnt_sel;
               cnt_d   = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_d = gnt_sel;
`endif
               if (gnt_sel == GNT_D) begin
                  // a simultaneous READ+WRITE is treated as a write
                  m_read_d      = ~D_WRITE;
                  m_write_d     = D_WRITE;
                  m_address_d   = D_ADDRESS;
                  m_writedata_d = D_WRITEDATA;
               end else begin
                  m_read_d    = 1'b1;
                  m_write_d   = 1'b0;
                  m_address_d = I_ADDRESS;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            if (cnt_d >= TIMEOUT_C) begin
               err_d = 1'b1;
            end
            if (!M_BUSYWAIT && (cnt_q != 8'd0)) begin
               state_d   = ST_DONE;
               m_read_d  = 1'b0;
               m_write_d = 1'b0;
               // a requester that dropped its request mid-access gets nothing
               if (m_read_q) begin
                  if (grant_q == GNT_D && D_READ && !D_WRITE) begin
                     d_readdata_d = M_READDATA;
                  end else if (grant_q == GNT_I && I_READ) begin
                     i_readdata_d = M_READDATA;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q       <= ST_IDLE;
         grant_q       <= GNT_I;
         m_read_q      <= 1'b0;
         m_write_q     <= 1'b0;
         m_address_q   <= '0;
         m_writedata_q <= '0;
         i_readdata_q  <= '0;
         d_readdata_q  <= '0;
         cnt_q         <= 8'd0;
         err_q         <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= GNT_I;
`endif
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         m_read_q      <= m_read_d;
         m_write_q     <= m_write_d;
         m_address_q   <= m_address_d;
         m_writedata_q <= m_writedata_d;
         i_readdata_q  <= i_readdata_d;
         d_readdata_q  <= d_readdata_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   assign I_BUSYWAIT  = req_i & ~((state_q == ST_DONE) & (grant_q == GNT_I));
   assign D_BUSYWAIT  = req_d & ~((state_q == ST_DONE) & (grant_q == GNT_D));
   assign M_READ      = m_read_q;
   assign M_WRITE     = m_write_q;
   assign M_ADDRESS   = m_address_q;
   assign M_WRITEDATA = m_writedata_q;
   assign I_READDATA  = i_readdata_q;
   assign D_READDATA  = d_readdata_q;
   assign ERR         = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small latency-programmable memory model.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        I_READ = 1'b0;
   logic [31:0] I_ADDRESS = '0;
   logic [31:0] I_READDATA;
   logic        I_BUSYWAIT;
   logic        D_READ = 1'b0;
   logic        D_WRITE = 1'b0;
   logic [31:0] D_ADDRESS = '0;
   logic [31:0] D_WRITEDATA = '0;
   logic [31:0] D_READDATA;
   logic        D_BUSYWAIT;
   logic        M_READ;
   logic        M_WRITE;
   logic [31:0] M_ADDRESS;
   logic [31:0] M_WRITEDATA;
   logic [31:0] M_READDATA = '0;
   logic        M_BUSYWAIT = 1'b0;
   logic        ERR;

   int n_checks = 0;
   int n_fail   = 0;

   int          mem_lat = 2;
   int          acc_n   = 0;
   logic [31:0] last_waddr = '0;
   logic [31:0] last_wdata = '0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
      .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
      .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
      .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
      .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h00A0_0093;
      return a ^ 32'hA5A5_0000;
   endfunction

   // memory stays busy for mem_lat cycles after a strobe appears
   always @(negedge CLK) begin
      if (M_READ === 1'b1 || M_WRITE === 1'b1) begin
         M_BUSYWAIT = (acc_n < mem_lat);
         acc_n      = acc_n + 1;
         M_READDATA = mem_rd(M_ADDRESS);
         if (M_WRITE === 1'b1) begin
            last_waddr = M_ADDRESS;
            last_wdata = M_WRITEDATA;
         end
      end else begin
         acc_n      = 0;
         M_BUSYWAIT = 1'b0;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_low(input bit side_d, input int budget, output int n);
      n = -1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if ((side_d ? D_BUSYWAIT : I_BUSYWAIT) === 1'b0) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      tick(); tick();
      RESET = 1'b1;
      #1;
      n_checks++; if (I_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_i_busywait got %b exp 0", I_BUSYWAIT); end
      n_checks++; if (D_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL reset_d_busywait got %b exp 0", D_BUSYWAIT); end
      n_checks++; if ({M_READ, M_WRITE} !== 2'b00) begin n_fail++; $display("FAIL reset_m_strobes got %b exp 00", {M_READ, M_WRITE}); end
      n_checks++; if (M_ADDRESS !== 32'h0) begin n_fail++; $display("FAIL reset_m_address got %h exp 0", M_ADDRESS); end
      n_checks++; if (I_READDATA !== 32'h0 || D_READDATA !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h/%h exp 0/0", I_READDATA, D_READDATA); end
      n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", ERR); end
   endtask

   task automatic test_fetch();
      int n;
      mem_lat = 2;
      I_READ = 1'b1; I_ADDRESS = 32'h100;
      #1;
      n_checks++; if (I_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_now got %b exp 1", I_BUSYWAIT); end
      tick();
      n_checks++; if (M_READ !== 1'b1 || M_ADDRESS !== 32'h100) begin n_fail++; $display("FAIL fetch_m_read got %b@%h exp 1@00000100", M_READ, M_ADDRESS); end
      wait_low(1'b0, 20, n);
      n_checks++; if (n !== 3) begin n_fail++; $display("FAIL fetch_latency got %0d exp 3", n); end
      n_checks++; if (I_READDATA !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_data got %h exp 00a00093", I_READDATA); end
      n_checks++; if (M_READ !== 1'b0) begin n_fail++; $display("FAIL fetch_done_strobe got %b exp 0", M_READ); end
      tick();
      n_checks++; if (I_BUSYWAIT !== 1'b1 || M_READ !== 1'b0) begin n_fail++; $display("FAIL fetch_one_cycle got bw=%b mr=%b exp bw=1 mr=0", I_BUSYWAIT, M_READ); end
      I_READ = 1'b0;
      tick();
      n_checks++; if (M_READ !== 1'b0 || I_READDATA !== 32'h00A0_0093) begin n_fail++; $display("FAIL fetch_idle got mr=%b data=%h exp 0/00a00093", M_READ, I_READDATA); end
   endtask

   task automatic test_back_to_back();
      int n;
      mem_lat = 0;
      I_READ = 1'b1; I_ADDRESS = 32'h200;
      tick();
      wait_low(1'b0, 20, n);
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL b2b_min_latency got %0d exp 2", n); end
      n_checks++; if (I_READDATA !== 32'hA5A5_0200) begin n_fail++; $display("FAIL b2b_data0 got %h exp a5a50200", I_READDATA); end
      I_ADDRESS = 32'h204;
      tick();
      n_checks++; if (M_READ !== 1'b0 || I_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL b2b_bubble got mr=%b bw=%b exp 0/1", M_READ, I_BUSYWAIT); end
      tick();
      n_checks++; if (M_READ !== 1'b1 || M_ADDRESS !== 32'h204) begin n_fail++; $display("FAIL b2b_second got %b@%h exp 1@00000204", M_READ, M_ADDRESS); end
      wait_low(1'b0, 20, n);
      n_checks++; if (n < 0 || I_READDATA !== 32'hA5A5_0204) begin n_fail++; $display("FAIL b2b_data1 got %h (n=%0d) exp a5a50204", I_READDATA, n); end
      I_READ = 1'b0;
      tick();
   endtask

   task automatic test_write();
      int n;
      logic [31:0] d_before;
      d_before = D_READDATA;
      mem_lat = 2;
      D_WRITE = 1'b1; D_ADDRESS = 32'h40; D_WRITEDATA = 32'hDEAD_BEEF;
      tick();
      n_checks++; if (M_WRITE !== 1'b1 || M_READ !== 1'b0) begin n_fail++; $display("FAIL write_strobes got w=%b r=%b exp 1/0", M_WRITE, M_READ); end
      n_checks++; if (M_ADDRESS !== 32'h40 || M_WRITEDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_addr_data got %h/%h exp 00000040/deadbeef", M_ADDRESS, M_WRITEDATA); end
      n_checks++; if (I_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL write_i_untouched got %b exp 0", I_BUSYWAIT); end
      wait_low(1'b1, 20, n);
      n_checks++; if (n !== 3) begin n_fail++; $display("FAIL write_latency got %0d exp 3", n); end
      n_checks++; if (last_waddr !== 32'h40 || last_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_mem got %h/%h exp 00000040/deadbeef", last_waddr, last_wdata); end
      n_checks++; if (D_READDATA !== d_before) begin n_fail++; $display("FAIL write_readdata got %h exp %h", D_READDATA, d_before); end
      D_WRITE = 1'b0;
      tick();
   endtask

   task automatic test_read_write_both();
      int n;
      mem_lat = 1;
      D_READ = 1'b1; D_ADDRESS = 32'h80;
      tick();
      wait_low(1'b1, 20, n);
      n_checks++; if (n < 0 || D_READDATA !== 32'hA5A5_0080) begin n_fail++; $display("FAIL dread_data got %h (n=%0d) exp a5a50080", D_READDATA, n); end
      D_READ = 1'b0;
      tick();
      D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 32'h44; D_WRITEDATA = 32'h1234_5678;
      tick();
      n_checks++; if (M_WRITE !== 1'b1 || M_READ !== 1'b0) begin n_fail++; $display("FAIL rw_both_strobes got w=%b r=%b exp 1/0", M_WRITE, M_READ); end
      wait_low(1'b1, 20, n);
      n_checks++; if (n < 0 || last_waddr !== 32'h44 || last_wdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_both_mem got %h/%h (n=%0d) exp 00000044/12345678", last_waddr, last_wdata, n); end
      n_checks++; if (D_READDATA !== 32'hA5A5_0080) begin n_fail++; $display("FAIL rw_both_readdata got %h exp a5a50080", D_READDATA); end
      D_READ = 1'b0; D_WRITE = 1'b0;
      tick();
   endtask

   task automatic test_drop();
      mem_lat = 4;
      D_READ = 1'b1; D_ADDRESS = 32'h300;
      tick(); tick();
      D_READ = 1'b0;
      #1;
      n_checks++; if (D_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL drop_busywait got %b exp 0", D_BUSYWAIT); end
      tick();
      n_checks++; if (M_READ !== 1'b1) begin n_fail++; $display("FAIL drop_no_abort got %b exp 1", M_READ); end
      for (int k = 0; k < 10; k++) tick();
      n_checks++; if (M_READ !== 1'b0 || D_READDATA !== 32'hA5A5_0080) begin n_fail++; $display("FAIL drop_discard got mr=%b data=%h exp 0/a5a50080", M_READ, D_READDATA); end
   endtask

   task automatic test_contention();
      bit          exp_seq [4];
      bit          got;
      bit          found;
      logic [31:0] i_addr;
      int          n;
`ifdef ARB_ROUND_ROBIN_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      mem_lat = 1;
      i_addr = 32'h500;
      I_READ = 1'b1; I_ADDRESS = i_addr;
      D_READ = 1'b1; D_ADDRESS = 32'h600;
      tick();
      n_checks++; if (M_ADDRESS !== 32'h600 || I_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL cont_first_d got %h bw_i=%b exp 00000600/1", M_ADDRESS, I_BUSYWAIT); end
      for (int g = 0; g < 4; g++) begin
         found = 1'b0;
         got   = 1'b0;
         for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (D_BUSYWAIT === 1'b0 || I_BUSYWAIT === 1'b0) begin
               found = 1'b1;
               got   = (D_BUSYWAIT === 1'b0);
            end
         end
         n_checks++;
         if (!found || got !== exp_seq[g]) begin
            n_fail++; $display("FAIL cont_grant%0d got %s exp %s", g, !found ? "none" : (got ? "D" : "I"), exp_seq[g] ? "D" : "I");
         end
         if (g == 0) begin
            n_checks++; if (D_READDATA !== 32'hA5A5_0600 || I_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL cont_d_data got %h bw_i=%b exp a5a50600/1", D_READDATA, I_BUSYWAIT); end
         end
         if (found && got) D_ADDRESS = D_ADDRESS + 32'd4;
         else if (found) begin i_addr = i_addr + 32'd4; I_ADDRESS = i_addr; end
      end
      D_READ = 1'b0;
      wait_low(1'b0, 20, n);
      n_checks++; if (n < 0 || I_READDATA !== (i_addr ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL cont_i_final got %h (n=%0d) exp %h", I_READDATA, n, i_addr ^ 32'hA5A5_0000); end
      I_READ = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n;
      mem_lat = 300;
      D_READ = 1'b1; D_ADDRESS = 32'h700;
      tick();
      for (int k = 0; k < 254; k++) tick();
      n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b exp 0", ERR); end
      tick();
      n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_at_255 got %b exp 1", ERR); end
      wait_low(1'b1, 100, n);
      n_checks++; if (n !== 46 || D_READDATA !== 32'hA5A5_0700) begin n_fail++; $display("FAIL timeout_complete got n=%0d data=%h exp 46/a5a50700", n, D_READDATA); end
      D_READ = 1'b0;
      tick(); tick();
      n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %b exp 1", ERR); end
   endtask

   task automatic test_reset_mid_access();
      mem_lat = 10;
      D_WRITE = 1'b1; D_ADDRESS = 32'h800; D_WRITEDATA = 32'hCAFE_F00D;
      tick();
      I_READ = 1'b1; I_ADDRESS = 32'h900;
      tick(); tick();
      n_checks++; if (M_WRITE !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got %b exp 1", M_WRITE); end
      RESET = 1'b0;
      tick();
      n_checks++; if ({M_READ, M_WRITE} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_strobes got %b exp 00", {M_READ, M_WRITE}); end
      n_checks++; if (M_ADDRESS !== 32'h0 || M_WRITEDATA !== 32'h0) begin n_fail++; $display("FAIL rst_mid_m_regs got %h/%h exp 0/0", M_ADDRESS, M_WRITEDATA); end
      n_checks++; if (ERR !== 1'b0 || I_READDATA !== 32'h0 || D_READDATA !== 32'h0) begin n_fail++; $display("FAIL rst_mid_regs got err=%b %h/%h exp 0 0/0", ERR, I_READDATA, D_READDATA); end
      n_checks++; if (I_BUSYWAIT !== 1'b1 || D_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL rst_mid_bw_req got %b%b exp 11", I_BUSYWAIT, D_BUSYWAIT); end
      I_READ = 1'b0; D_WRITE = 1'b0;
      #1;
      n_checks++; if (I_BUSYWAIT !== 1'b0 || D_BUSYWAIT !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bw_noreq got %b%b exp 00", I_BUSYWAIT, D_BUSYWAIT); end
      RESET = 1'b1;
      tick();
      n_checks++; if (M_READ !== 1'b0 || M_WRITE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got %b%b exp 00", M_READ, M_WRITE); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_write();
      test_read_write_both();
      test_drop();
      test_contention();
      test_timeout();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
